// File: rtl/hash_output_sequencer_if.sv
// Core-array / shift-register / consumer bundle for hash_output_sequencer.
// master = sequencer side, slave = cores + shift register + consumer side.
interface hash_output_sequencer_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned STATE_W = 256;

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*STATE_W-1:0] req_state;
  logic [NUM_REQ-1:0]         req_ack;
  logic                       sr_write_en;
  logic [STATE_W-1:0]         sr_state;
  logic                       out_valid;
  logic                       out_first;
  logic                       out_last;
  logic [2:0]                 out_idx;
  logic [SRC_W-1:0]           out_src;
  logic                       busy;

  modport master (
    input  req_valid, req_state,
    output req_ack, sr_write_en, sr_state,
    output out_valid, out_first, out_last, out_idx, out_src, busy
  );

  modport slave (
    output req_valid, req_state,
    input  req_ack, sr_write_en, sr_state,
    input  out_valid, out_first, out_last, out_idx, out_src, busy
  );
endinterface

// File: rtl/hash_output_sequencer.sv
// Arbitrates finished SHA-256 cores onto the 8-word output shift register and tags the words.
// HASH_SEQ_RR_ARB_EN defined: round-robin arbitration; undefined: fixed priority, lowest index wins.
module hash_output_sequencer #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  hash_output_sequencer_if.master bus
);
  localparam int unsigned SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned STATE_W = 256;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SRC_W-1:0]   r_src;
  logic [SRC_W-1:0]   w_src_nxt;
`ifdef HASH_SEQ_RR_ARB_EN
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [SRC_W-1:0]   w_rr_ptr_nxt;
`endif
  logic               w_any;
  logic [SRC_W-1:0]   w_gidx;
  logic               w_slot;
  logic               w_grant;
  logic               w_stream;
  logic [NUM_REQ-1:0] w_ack;
  logic [STATE_W-1:0] w_sr_state;

  // Arbiter: picks the winning requester index (valid only when w_any)
  always_comb begin : p_arb
`ifdef HASH_SEQ_RR_ARB_EN
    int d;
    int best;
    int rr;
`endif
    w_any  = 1'b0;
    w_gidx = '0;
`ifdef HASH_SEQ_RR_ARB_EN
    d    = 0;
    best = 0;
    rr   = int'(r_rr_ptr);
    // Smallest wrapped distance from rr_ptr wins
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      d = (i >= rr) ? (i - rr) : (i + int'(NUM_REQ) - rr);
      if (bus.req_valid[i] && (!w_any || (d < best))) begin
        w_any  = 1'b1;
        best   = d;
        w_gidx = SRC_W'(i);
      end
    end
`else
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (bus.req_valid[i] && !w_any) begin
        w_any  = 1'b1;
        w_gidx = SRC_W'(i);
      end
    end
`endif
  end

  // Next-state and grant-cycle outputs; a load is only allowed in IDLE or on the last word
  always_comb begin : p_fsm
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_src_nxt   = r_src;
`ifdef HASH_SEQ_RR_ARB_EN
    w_rr_ptr_nxt = r_rr_ptr;
`endif
    w_slot     = 1'b0;
    w_ack      = '0;
    w_sr_state = '0;

    case (r_state)
      S_IDLE: begin
        w_slot = 1'b1;
      end
      S_STREAM: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(7)) begin
          w_slot      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase

    // rst gates the combinational grant so every output is 0 while reset is held
    w_grant = w_slot && w_any && !rst;

    if (w_grant) begin
      w_state_nxt = S_STREAM;
      w_cnt_nxt   = '0;
      w_src_nxt   = w_gidx;
`ifdef HASH_SEQ_RR_ARB_EN
      w_rr_ptr_nxt = (w_gidx == SRC_W'(NUM_REQ - 1)) ? '0 : (w_gidx + SRC_W'(1));
`endif
    end

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_grant && (w_gidx == SRC_W'(i))) begin
        w_ack[i]   = 1'b1;
        w_sr_state = bus.req_state[i*STATE_W +: STATE_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_src   <= '0;
`ifdef HASH_SEQ_RR_ARB_EN
      r_rr_ptr <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_src   <= w_src_nxt;
`ifdef HASH_SEQ_RR_ARB_EN
      r_rr_ptr <= w_rr_ptr_nxt;
`endif
    end
  end

  // Word tags decode registered state only
  assign w_stream        = (r_state == S_STREAM);
  assign bus.req_ack     = w_ack;
  assign bus.sr_write_en = w_grant;
  assign bus.sr_state    = w_sr_state;
  assign bus.out_valid   = w_stream;
  assign bus.out_first   = w_stream && (r_cnt == CNT_W'(0));
  assign bus.out_last    = w_stream && (r_cnt == CNT_W'(7));
  assign bus.out_idx     = w_stream ? r_cnt : '0;
  assign bus.out_src     = w_stream ? r_src : '0;
  assign bus.busy        = w_stream;
endmodule

// File: tb/tb_hash_output_sequencer.sv
// Scoreboard bench for hash_output_sequencer: a 4-core instance and a single-core instance.
module tb_hash_output_sequencer;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CW      = 300;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  logic [255:0] st  [4];
  logic [255:0] st1 [3];

  logic [259:0] q_load  [$];
  logic [6:0]   q_word  [$];
  logic [255:0] q1_load [$];
  logic [5:0]   q1_word [$];

  hash_output_sequencer_if #(.NUM_REQ(NUM_REQ)) bus ();
  hash_output_sequencer_if #(.NUM_REQ(1))       bus1 ();

  hash_output_sequencer #(.NUM_REQ(NUM_REQ)) dut  (.clk(clk), .rst(rst), .bus(bus));
  hash_output_sequencer #(.NUM_REQ(1))       dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_grant(input int g);
    q_load.push_back({4'(1 << g), st[g]});
    for (int k = 0; k < 8; k++) q_word.push_back({2'(g), 3'(k), (k == 0), (k == 7)});
  endtask

  // One clock; afterwards the cores drop any request that was acked in that cycle
  task automatic tick();
    logic [3:0] a0;
    logic       a1;
    @(negedge clk);
    a0 = bus.req_ack;
    a1 = bus1.req_ack;
    @(posedge clk);
    #1;
    bus.req_valid  = bus.req_valid & ~a0;
    bus1.req_valid = bus1.req_valid & ~a1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid  = '0;
    bus1.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && (q_load.size() + q_word.size() + q1_load.size() + q1_word.size()) != 0; k++)
      @(posedge clk);
    #1;
    chk({tag, "_pending"}, CW'(q_load.size() + q_word.size() + q1_load.size() + q1_word.size()), CW'(0));
    chk({tag, "_busy"}, CW'({bus.busy, bus1.busy}), CW'(0));
  endtask

  // Monitor for the 4-core instance
  always @(negedge clk) begin : mon0
    logic [259:0] el;
    logic [6:0]   ew;
    if (bus.sr_write_en || (bus.req_ack != '0)) begin
      if (q_load.size() == 0) begin
        chk("load_extra", CW'({bus.req_ack, bus.sr_write_en}), CW'(0));
      end else begin
        el = q_load.pop_front();
        chk("load_ack", CW'(bus.req_ack), CW'(el[259:256]));
        chk("load_we", CW'(bus.sr_write_en), CW'(1));
        chk("load_state", CW'(bus.sr_state), CW'(el[255:0]));
      end
    end else begin
      chk("sr_state_zero", CW'(bus.sr_state), CW'(0));
    end
    if (bus.out_valid) begin
      if (q_word.size() == 0) begin
        chk("word_extra", CW'({bus.out_valid, bus.out_idx, bus.out_src}), CW'(0));
      end else begin
        ew = q_word.pop_front();
        chk("word_tags", CW'({bus.out_src, bus.out_idx, bus.out_first, bus.out_last}), CW'(ew));
      end
    end
  end

  // Monitor for the single-core instance
  always @(negedge clk) begin : mon1
    logic [255:0] el;
    logic [5:0]   ew;
    if (bus1.sr_write_en || bus1.req_ack[0]) begin
      if (q1_load.size() == 0) begin
        chk("n1_load_extra", CW'({bus1.req_ack, bus1.sr_write_en}), CW'(0));
      end else begin
        el = q1_load.pop_front();
        chk("n1_load_ack", CW'({bus1.req_ack, bus1.sr_write_en}), CW'(3));
        chk("n1_load_state", CW'(bus1.sr_state), CW'(el));
      end
    end
    if (bus1.out_valid) begin
      if (q1_word.size() == 0) begin
        chk("n1_word_extra", CW'({bus1.out_valid, bus1.out_idx}), CW'(0));
      end else begin
        ew = q1_word.pop_front();
        chk("n1_word_tags", CW'({bus1.out_src, bus1.out_idx, bus1.out_first, bus1.out_last}), CW'(ew));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nval;
    st[0]  = {8{32'h1111_0000}};
    st[1]  = {8{32'h2222_0101}};
    st[2]  = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    st[3]  = {8{32'h4444_0303}};
    st1[0] = {8{32'ha5a5_0000}};
    st1[1] = {8{32'h5a5a_1111}};
    st1[2] = {8{32'hc3c3_2222}};

    rst            = 1'b1;
    bus.req_valid  = '0;
    bus.req_state  = {st[3], st[2], st[1], st[0]};
    bus1.req_valid = '0;
    bus1.req_state = st1[0];
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", CW'({bus.req_ack, bus.sr_write_en, bus.out_valid, bus.out_first, bus.out_last,
                           bus.out_idx, bus.out_src, bus.busy}), CW'(0));
    chk("reset_sr_state", CW'(bus.sr_state), CW'(0));
    rst = 1'b0;

    // Single request from core 2 carrying the SHA-256 IV
    exp_grant(2);
    bus.req_valid = 4'b0100;
    tick();
    drain("t1");

    // All cores requesting continuously
    do_reset();
`ifdef HASH_SEQ_RR_ARB_EN
    for (int k = 0; k < 5; k++) exp_grant(k % 4);
`else
    for (int k = 0; k < 5; k++) exp_grant(0);
`endif
    nval = 0;
    bus.req_valid = 4'b1111;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.out_valid) nval++;
      bus.req_valid = (c <= 32) ? 4'b1111 : 4'b0000;
    end
    chk("all_req_valid_cycles", CW'(nval), CW'(40));
    drain("t2");

    // Core 1 arrives at cnt=3 of a core 0 stream
    do_reset();
    exp_grant(0);
    exp_grant(1);
    bus.req_valid = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 4) bus.req_valid = bus.req_valid | 4'b0010;
    end
    drain("t3");

    // Async reset mid-cycle at cnt=4; only words 0..3 get out
    do_reset();
    q_load.push_back({4'b0001, st[0]});
    for (int k = 0; k < 4; k++) q_word.push_back({2'd0, 3'(k), (k == 0), 1'b0});
    bus.req_valid = 4'b0001;
    repeat (5) tick();
    chk("pre_rst_idx", CW'({bus.out_valid, bus.out_idx}), CW'({1'b1, 3'd4}));
    #2;
    rst = 1'b1;
    bus.req_valid = 4'b1000;
    #1;
    chk("async_rst_outs", CW'({bus.req_ack, bus.sr_write_en, bus.out_valid, bus.out_first, bus.out_last,
                               bus.out_idx, bus.out_src, bus.busy}), CW'(0));
    chk("async_rst_sr_state", CW'(bus.sr_state), CW'(0));
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst = 1'b0;
    nval = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.out_valid || bus.busy) nval++;
    end
    chk("post_rst_idle_cycles", CW'(nval), CW'(0));
    drain("t4");

    // Core 3 pulses its request mid-stream and withdraws before the last word
    do_reset();
    exp_grant(0);
    bus.req_valid = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 2) bus.req_valid = 4'b1000;
      if (c == 5) bus.req_valid = 4'b0000;
    end
    drain("t5");

    // Single-core build: three back-to-back streams with a fresh state each load
    do_reset();
    for (int k = 0; k < 3; k++) begin
      q1_load.push_back(st1[k]);
      for (int j = 0; j < 8; j++) q1_word.push_back({1'b0, 3'(j), (j == 0), (j == 7)});
    end
    nval = 0;
    bus1.req_state = st1[0];
    bus1.req_valid = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (bus1.out_valid) nval++;
      if (c <= 16) begin
        bus1.req_state = st1[(c + 7) / 8];
        bus1.req_valid = 1'b1;
      end
    end
    chk("n1_valid_cycles", CW'(nval), CW'(24));
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hash_output_sequencer.md
Name: hash_output_sequencer

Overview:
- Sequences the 8-word hash-state output shift register for several SHA-256 cores.
- Arbitrates among NUM_REQ cores with finished digests and muxes the winner's 256-bit state onto the register load port.
- Pulses the register's write enable, then qualifies the 8 serialised 32-bit words with valid/first/last/index/source tags for the downstream consumer.
- Sits between the core array and the result/nonce-check path.

Parameters:
- NUM_REQ, 4, number of requesting hash cores (>=1).
- SRC_W, max(1,$clog2(NUM_REQ)), width of the source-index field; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  core i holds a finished digest; held high until req_ack[i].
- req_state  input  NUM_REQ*256  core i state at [i*256 +: 256]; word a at bits [255:224], h at [31:0].
- req_ack  output  NUM_REQ  one-cycle pulse; core i's state is captured this cycle.
- sr_write_en  output  1  load strobe to the shift register.
- sr_state  output  256  muxed state of the granted core; all zeros when sr_write_en=0.
- out_valid  output  1  the shift register output word is a valid digest word this cycle.
- out_first  output  1  word a (index 0).
- out_last  output  1  word h (index 7).
- out_idx  output  3  word index 0..7.
- out_src  output  SRC_W  core index of the digest being streamed.
- busy  output  1  FSM not in IDLE.

Behaviour:
- Reset (async, any cycle including mid-stream):
  - FSM=IDLE, cnt=0, rr_ptr=0.
  - All outputs 0.
  - A stream in progress is dropped. Its ack was already issued and is not reissued.
- Shift register contract: a load in cycle T presents words a..h on the register output in cycles T+1..T+8.
- States: IDLE, STREAM. cnt is a 3-bit counter.
- IDLE:
  - If any req_valid bit is set, in that same cycle assert sr_write_en=1 and req_ack[g]=1, drive sr_state=req_state[g], register src<=g, set cnt<=0, and go to STREAM.
  - Otherwise stay in IDLE.
- STREAM:
  - out_valid=1, out_idx=cnt, out_first=(cnt==0), out_last=(cnt==7), out_src=src.
  - cnt increments each cycle. The stream has no backpressure, so the consumer must accept every word.
- At cnt==7:
  - If any req_valid bit is set, perform a load in the same cycle, as in IDLE. The next cycle is cnt=0 of the new stream, with no bubble.
  - Otherwise go to IDLE.
- Grants in STREAM at cnt!=7: none. req_ack stays 0 and requests wait.
- Grant g: per arbitration policy (see Optional Feature). With the feature enabled, rr_ptr<=(g+1) mod NUM_REQ on every grant. With it disabled, rr_ptr is unused and held at 0.
- Only the grant cycle is combinational from req_valid. All other outputs decode registered state.
- A core that drops req_valid before being acked is simply not granted. This is not an error.
- NUM_REQ=1: no arbitration; g=0 always.
- Throughput: one digest per 8 cycles maximum. Latency from req_valid in IDLE to out_first is 1 cycle.

Optional Feature:
- Macro HASH_SEQ_RR_ARB_EN.
- Defined: round-robin arbitration. Search starts at rr_ptr and wraps; the first requester found wins.
- Undefined: fixed priority, lowest index wins. A core held off by a lower index is allowed to starve.

Test Plan:
- Reset, then req_valid=4'b0100 with core2 state words a=0x6a09e667..h=0x5be0cd19:
  - Same cycle: req_ack=4'b0100 and sr_write_en=1.
  - Next 8 cycles: out_valid=1, out_idx=0..7, out_first on idx 0, out_last on idx 7, out_src=2.
  - Then busy=0.
- req_valid=4'b1111 held, re-raised after each ack:
  - With HASH_SEQ_RR_ARB_EN: grants 0,1,2,3,0 on cycles 0,8,16,24,32, back-to-back with out_valid continuous.
  - Without the macro: grants 0,0,0,...
- Request on core1 arriving at cnt=3 of a core0 stream: no ack until the cnt=7 cycle. There, ack[1]=1 and sr_write_en=1, and the next cycle is out_idx=0 with out_src=1.
- rst asserted asynchronously mid-cycle at cnt=4:
  - All outputs go to 0 immediately, before the next clk edge.
  - After release with no req_valid: the FSM stays IDLE and out_valid stays 0.
- Core3 raises then drops req_valid while a stream is active (never reaches cnt=7 window): no ack to core3 and no spurious load.
- NUM_REQ=1 build: repeated requests yield continuous 8-word streams with out_src=0 and sr_state equal to req_state on each load cycle.
